// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 program loader: FSM state encoding,
// header word layout and the HLT opcode word.
package mips32_pkg;

    // state  | meaning
    // IDLE   | waiting for a header word, processor held
    // LOAD   | streaming program words into memory
    // START  | one-cycle release pulse to the processor
    // RUN    | processor free-running, watching HALTED and the timeout
    // DONE   | run finished, flags and cycle count frozen until next header
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_e;

    localparam logic [31:0] HLT_WORD = 32'hFC000000;

    localparam int HDR_FIELD_W   = 16;
    localparam int HDR_BASE_MSB  = 31;
    localparam int HDR_BASE_LSB  = 16;
    localparam int HDR_COUNT_MSB = 15;
    localparam int HDR_COUNT_LSB = 0;

    // True when [base, base+count) fits inside a memory of 'depth' words.
    // The sum is taken one bit wider than the fields so it cannot wrap.
    function automatic logic hdr_in_range(input logic [HDR_FIELD_W-1:0] base,
                                          input logic [HDR_FIELD_W-1:0] count,
                                          input int depth);
        logic [HDR_FIELD_W:0] end_addr;
        end_addr = {1'b0, base} + {1'b0, count};
        return end_addr <= (HDR_FIELD_W + 1)'(depth);
    endfunction

endpackage

// File: rtl/mips32_run_timer.sv
// RUN-phase cycle counter: synchronous clear, count enable and a terminal
// flag that is high while the count equals TERMINAL-1.
module mips32_run_timer #(
    parameter int CNT_WIDTH = 16,
    parameter int TERMINAL  = 2048
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 enable_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 terminal_o
);

    logic [CNT_WIDTH-1:0] count_q;

    // Count up while enabled; clear has priority so START always begins at zero.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == CNT_WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/mips32_prog_loader.sv
// Program loader for pipe_MIPS32: takes a header word (base, count) and
// 'count' program words, writes them into the unified memory, releases the
// processor with a start pulse and then waits for HALTED or a timeout.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int MEM_DEPTH      = 1024,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  cpu_start,
    input  logic                  cpu_halted,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  load_err,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [HDR_FIELD_W-1:0] count_q, count_d;
    logic [HDR_FIELD_W-1:0] idx_q, idx_d;
    logic                  load_err_q, load_err_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic                   ready_state;
    logic                   in_accept;
    logic [HDR_FIELD_W-1:0] hdr_base;
    logic [HDR_FIELD_W-1:0] hdr_count;
    logic                   hdr_ok;
    logic                   timer_clear;
    logic                   timer_enable;
    logic                   timer_terminal;
    logic [CNT_WIDTH-1:0]   run_count;
    logic                   first_run_cycle;

    // in_ready depends only on the state register (and reset), never on in_valid.
    assign ready_state = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign in_ready    = ready_state && !rst;
    assign in_accept   = in_valid && in_ready;

    assign hdr_base  = in_data[HDR_BASE_MSB:HDR_BASE_LSB];
    assign hdr_count = in_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
    assign hdr_ok    = hdr_in_range(hdr_base, hdr_count, MEM_DEPTH);

    // The processor may still show HALTED from the previous program during
    // the first RUN cycle, so a halt is only trusted once the count moved.
    assign first_run_cycle = (run_count == '0);

    mips32_run_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .TERMINAL  (TIMEOUT_CYCLES)
    ) u_run_timer (
        .clk1       (clk1),
        .rst        (rst),
        .clear_i    (timer_clear),
        .enable_i   (timer_enable),
        .count_o    (run_count),
        .terminal_o (timer_terminal)
    );

    // Next-state logic for the loader FSM, header fields, flags and write port.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        count_d      = count_q;
        idx_d        = idx_q;
        load_err_d   = load_err_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (in_accept) begin
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    load_err_d = !hdr_ok;
                    base_d     = hdr_base[ADDR_WIDTH-1:0];
                    count_d    = hdr_count;
                    idx_d      = '0;
                    if (hdr_count == '0) begin
                        // Nothing to drain: a legal empty program runs at once,
                        // an illegal one just reports the error.
                        state_d = hdr_ok ? ST_START : ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (in_accept) begin
                    mem_we_d    = !load_err_q;
                    mem_addr_d  = base_q + idx_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = in_data;
                    idx_d       = idx_q + {{(HDR_FIELD_W-1){1'b0}}, 1'b1};
                    if (idx_d == count_q) begin
                        state_d = load_err_q ? ST_IDLE : ST_START;
                    end
                end
            end
            ST_START: begin
                timer_clear = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                timer_enable = 1'b1;
                if (cpu_halted && !first_run_cycle) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (timer_terminal) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load or run in progress.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            load_err_q  <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            load_err_q  <= load_err_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_start   = (state_q == ST_START);
    assign cpu_hold    = !((state_q == ST_START) || (state_q == ST_RUN));
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_START) || (state_q == ST_RUN);
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign load_err    = load_err_q;
    assign cycle_count = run_count;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Scoreboard bench for mips32_prog_loader: stimulus pushes expected memory
// writes and run outcomes, a negedge monitor pops and compares them.
module tb_mips32_prog_loader;
    import mips32_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int CW    = 16;
    localparam int TO    = 64;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          cpu_start;
    logic          cpu_halted;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          load_err;
    logic [CW-1:0] cycle_count;

    mips32_prog_loader #(
        .ADDR_WIDTH     (AW),
        .MEM_DEPTH      (DEPTH),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_start   (cpu_start),
        .cpu_halted  (cpu_halted),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .load_err    (load_err),
        .cycle_count (cycle_count)
    );

    always #5 clk1 = ~clk1;

    // Processor stand-in: HALTED keeps its old value through the first
    // released cycle, then rises once it has run halt_after cycles.
    int halt_after = 39;
    int run_k;
    always @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cpu_halted <= 1'b1;
            run_k      <= 0;
        end else if (cpu_start) begin
            run_k <= 0;
        end else if (!cpu_hold) begin
            run_k      <= run_k + 1;
            cpu_halted <= (run_k + 1 >= halt_after);
        end
    end

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { bit err; bit dn; bit to; int cnt; int starts; } res_t;

    wr_t  exp_wr_q[$];
    res_t exp_res_q[$];
    int   errors = 0;
    int   checks = 0;
    int   model_cnt = 0;
    logic [31:0] dut_mem [0:DEPTH-1];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    bit   prev_busy = 0;
    int   starts = 0;
    wr_t  mw;
    res_t mr;
    initial begin
        forever begin
            @(negedge clk1);
            if (rst) begin
                prev_busy = 0;
                starts    = 0;
            end else begin
                if (mem_we) begin
                    if (exp_wr_q.size() == 0) begin
                        chk("unexpected_write_addr", mem_addr, -1);
                    end else begin
                        mw = exp_wr_q.pop_front();
                        chk("wr_addr", mem_addr, mw.addr);
                        chk("wr_data", mem_wdata, mw.data);
                    end
                    dut_mem[mem_addr] = mem_wdata;
                end
                if (!cpu_hold) chk("in_ready_while_running", in_ready, 0);
                if (busy && !prev_busy) starts = int'(cpu_start);
                else if (busy) starts += int'(cpu_start);
                if (!busy && prev_busy) begin
                    if (exp_res_q.size() == 0) begin
                        chk("unexpected_end_of_job", 1, 0);
                    end else begin
                        mr = exp_res_q.pop_front();
                        chk("load_err", load_err, mr.err);
                        chk("done", done, mr.dn);
                        chk("timeout", timeout, mr.to);
                        chk("cycle_count", cycle_count, mr.cnt);
                        chk("start_pulses", starts, mr.starts);
                        chk("cpu_hold_after", cpu_hold, 1);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic send(input logic [31:0] w, input int gap_pct);
        while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk1); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 3000; t++) begin
            if (in_ready) begin
                @(posedge clk1); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk1); #1;
        end
        in_valid = 1'b0;
        chk("accept_wait_expired", 0, 1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 5000; t++) begin
            if (!busy) break;
            @(posedge clk1); #1;
        end
        if (busy) chk("idle_wait_expired", 1, 0);
        @(posedge clk1); #1;
    endtask

    // Reference: a legal job writes base+i, runs once and ends on whichever
    // of halt (seen in run cycle h+1) or timeout (run cycle TO) comes first.
    task automatic do_load(input int base, input int cnt, input logic [31:0] words[$],
                           input int h, input int gap);
        res_t r;
        bit   err;
        err = (base + cnt > DEPTH);
        halt_after = h;
        if (!err) begin
            for (int i = 0; i < cnt; i++) exp_wr_q.push_back('{base + i, words[i]});
            if (h + 1 <= TO) r = '{0, 1, 0, h + 1, 1};
            else             r = '{0, 0, 1, TO, 1};
            model_cnt = r.cnt;
        end else begin
            r = '{1, 0, 0, model_cnt, 0};
        end
        exp_res_q.push_back(r);
        send({base[15:0], cnt[15:0]}, gap);
        for (int i = 0; i < cnt; i++) send(words[i], gap);
        wait_idle();
    endtask

    task automatic check_reset();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
    endtask

    function automatic void rand_words(output logic [31:0] q[$], input int n);
        q = {};
        for (int i = 0; i < n; i++) q.push_back($urandom);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] prog[$];
    logic [31:0] rw[$];
    logic [31:0] none[$];
    initial begin
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, HLT_WORD};
        none = {};
        repeat (3) @(posedge clk1);
        #1;
        check_reset();
        rst = 1'b0;
        @(posedge clk1); #1;

        // ADD program, back-to-back words, halt in run cycle 40
        for (int i = 0; i < 9; i++) dut_mem[i] = '0;
        do_load(0, 9, prog, 39, 0);
        for (int i = 0; i < 9; i++) chk("image_t1", dut_mem[i], prog[i]);

        // same load with 50% input gaps
        for (int i = 0; i < 9; i++) dut_mem[i] = '0;
        do_load(0, 9, prog, 39, 50);
        for (int i = 0; i < 9; i++) chk("image_t2", dut_mem[i], prog[i]);

        // out of range header drains words; exact fit at the top is legal
        rand_words(rw, 8);
        do_load(1020, 8, rw, 5, 0);
        rand_words(rw, 8);
        do_load(1016, 8, rw, 20, 30);

        // processor never halts
        rand_words(rw, 5);
        do_load($urandom_range(0, 900), 5, rw, 100000, 20);

        // reset after word 3 of 9
        halt_after = 39;
        for (int i = 0; i < 3; i++) exp_wr_q.push_back('{i, prog[i]});
        send(32'h0000_0009, 0);
        for (int i = 0; i < 3; i++) send(prog[i], 0);
        @(posedge clk1); #1;
        rst = 1'b1;
        #1;
        check_reset();
        model_cnt = 0;
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        @(posedge clk1); #1;
        do_load(0, 9, prog, 39, 0);

        // empty program, then halt coinciding with timeout, then halt one late
        do_load(0, 0, none, 7, 0);
        rand_words(rw, 3);
        do_load(200, 3, rw, TO - 1, 0);
        rand_words(rw, 3);
        do_load(300, 3, rw, TO, 0);

        // random jobs
        for (int j = 0; j < 8; j++) begin
            int b, c;
            b = $urandom_range(0, 1023);
            c = $urandom_range(1, 12);
            rand_words(rw, c);
            do_load(b, c, rw, $urandom_range(1, 80), $urandom_range(0, 60));
        end

        chk("writes_outstanding", exp_wr_q.size(), 0);
        chk("jobs_outstanding", exp_res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
